// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and types for the iterative round engine.
// Table entries use the standard 1-based DES bit numbering.
package des_pkg;

  typedef logic [0:31] half_t;
  typedef logic [0:27] cd_half_t;
  typedef logic [0:55] key56_t;
  typedef logic [0:47] subkey_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SHIFT_TAB  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int RSHIFT_TAB [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box row-major: index = row*16 + col, row from the outer bits.
  localparam int SBOX_TAB [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(IP_TAB[i] - 1)];
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    for (int i = 0; i < 64; i++) y[i] = x[6'(FP_TAB[i] - 1)];
    return y;
  endfunction

  function automatic key56_t pc1_perm(input logic [0:63] x);
    key56_t y;
    for (int i = 0; i < 56; i++) y[i] = x[6'(PC1_TAB[i] - 1)];
    return y;
  endfunction

  function automatic subkey_t pc2_perm(input key56_t x);
    subkey_t y;
    for (int i = 0; i < 48; i++) y[i] = x[6'(PC2_TAB[i] - 1)];
    return y;
  endfunction

  function automatic subkey_t e_perm(input half_t x);
    subkey_t y;
    for (int i = 0; i < 48; i++) y[i] = x[5'(E_TAB[i] - 1)];
    return y;
  endfunction

  function automatic half_t p_perm(input half_t x);
    half_t y;
    for (int i = 0; i < 32; i++) y[i] = x[5'(P_TAB[i] - 1)];
    return y;
  endfunction

  // idx is the 0-based round number; decrypt walks the schedule backwards.
  function automatic logic [1:0] shift_amt(input logic [3:0] idx, input logic decrypt);
    return decrypt ? 2'(RSHIFT_TAB[idx]) : 2'(SHIFT_TAB[idx]);
  endfunction

endpackage

// File: rtl/des_feistel.sv
// DES round function f(R, K): expand, mix with subkey, S-box substitute, permute.
module des_feistel
  import des_pkg::*;
(
  input  half_t   r_in,
  input  subkey_t subkey,
  output half_t   f_out
);

  subkey_t     x;
  half_t       sb;
  logic [5:0]  six;

  always_comb begin
    x   = e_perm(r_in) ^ subkey;
    sb  = '0;
    six = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[6*s +: 6];
      sb[4*s +: 4] = 4'(SBOX_TAB[s][{six[5], six[0], six[4:1]}]);
    end
    f_out = p_perm(sb);
  end

endmodule

// File: rtl/des_key_step.sv
// One step of the on-the-fly key schedule: rotate C/D (left to encrypt, right to decrypt), then PC2.
module des_key_step
  import des_pkg::*;
(
  input  cd_half_t   c_in,
  input  cd_half_t   d_in,
  input  logic [1:0] shift,
  input  logic       decrypt,
  output cd_half_t   c_out,
  output cd_half_t   d_out,
  output subkey_t    subkey
);

  function automatic cd_half_t rot28(input cd_half_t x, input logic [1:0] sh, input logic right);
    case (sh)
      2'd1:    return right ? {x[27], x[0:26]} : {x[1:27], x[0]};
      2'd2:    return right ? {x[26:27], x[0:25]} : {x[2:27], x[0:1]};
      default: return x;
    endcase
  endfunction

  always_comb begin
    c_out  = rot28(c_in, shift, decrypt);
    d_out  = rot28(d_in, shift, decrypt);
    subkey = pc2_perm({c_out, d_out});
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES core: UNROLL Feistel rounds per clock with the key schedule computed alongside.
module des_round_engine
  import des_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter bit USE_IP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_block,
  input  logic [0:63] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_block,
  output logic        busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_round_engine: UNROLL=%0d must be one of 1,2,4,8,16", UNROLL);
  end

  state_t      state_q, state_d;
  half_t       l_q, l_d, r_q, r_d;
  cd_half_t    c_q, c_d, d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [0:63] out_block_q, out_block_d;

  half_t       l_fin, r_fin;
  cd_half_t    c_fin, d_fin;
  logic [0:63] pre_out, result, loaded;
  key56_t      key56;
  logic        accept;

  // Stage u handles 0-based round cnt_q+u; stages are chained through the generate scope.
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    half_t      l_in, r_in, l_out, r_out, f_out;
    cd_half_t   c_in, d_in, c_out, d_out;
    subkey_t    subkey;
    logic [1:0] shift;

    if (u == 0) begin : g_head
      assign l_in = l_q;
      assign r_in = r_q;
      assign c_in = c_q;
      assign d_in = d_q;
    end else begin : g_link
      assign l_in = g_round[u-1].l_out;
      assign r_in = g_round[u-1].r_out;
      assign c_in = g_round[u-1].c_out;
      assign d_in = g_round[u-1].d_out;
    end

    assign shift = shift_amt(4'(cnt_q + 5'(u)), dec_q);

    des_key_step u_key_step (
      .c_in    (c_in),
      .d_in    (d_in),
      .shift   (shift),
      .decrypt (dec_q),
      .c_out   (c_out),
      .d_out   (d_out),
      .subkey  (subkey)
    );

    des_feistel u_feistel (
      .r_in   (r_in),
      .subkey (subkey),
      .f_out  (f_out)
    );

    assign l_out = r_in;
    assign r_out = l_in ^ f_out;
  end

  assign l_fin = g_round[UNROLL-1].l_out;
  assign r_fin = g_round[UNROLL-1].r_out;
  assign c_fin = g_round[UNROLL-1].c_out;
  assign d_fin = g_round[UNROLL-1].d_out;

  assign pre_out = {r_fin, l_fin};
  assign result  = USE_IP ? fp_perm(pre_out) : pre_out;
  assign loaded  = USE_IP ? ip_perm(in_block) : in_block;
  assign key56   = pc1_perm(in_key);

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_ready && in_valid;
  assign out_valid = (state_q == DONE);
  assign out_block = out_block_q;
  assign busy      = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    out_block_d = out_block_q;

    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        l_d   = l_fin;
        r_d   = r_fin;
        c_d   = c_fin;
        d_d   = d_fin;
        cnt_d = cnt_q + 5'(UNROLL);
        if (cnt_d == 5'd16) begin
          out_block_d = result;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE or DONE, so it never collides with a round update.
    if (accept) begin
      l_d   = loaded[0:31];
      r_d   = loaded[32:63];
      c_d   = key56[0:27];
      d_d   = key56[28:55];
      dec_d = in_decrypt;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      out_block_q <= out_block_d;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: known-answer vectors, handshake/reset corner cases and
// randomized blocks on every legal UNROLL, checked against a plain DES model.
module tb_des_round_engine;
  import des_pkg::*;

  localparam int NI = 6;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K3  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT3 = 64'h8787878787878787;
  localparam logic [63:0] CT3 = 64'h0000000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid   [NI];
  logic        in_ready   [NI];
  logic [0:63] in_block   [NI];
  logic [0:63] in_key     [NI];
  logic        in_decrypt [NI];
  logic        out_valid  [NI];
  logic        out_ready  [NI];
  logic [0:63] out_block  [NI];
  logic        busy       [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instances 0..4 cover UNROLL 1,2,4,8,16 with IP/FP; instance 5 is UNROLL=4 without IP/FP.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_round_engine #(
      .UNROLL (g < 5 ? (1 << g) : 4),
      .USE_IP (g < 5)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_block   (in_block[g]),
      .in_key     (in_key[g]),
      .in_decrypt (in_decrypt[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_block  (out_block[g]),
      .busy       (busy[g])
    );
  end

  function automatic int unroll_of(input int u);
    return (u < 5) ? (1 << u) : 4;
  endfunction

  function automatic bit use_ip_of(input int u);
    return u < 5;
  endfunction

  function automatic logic [0:31] ref_f(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s_out, y;
    int row, col, v;
    for (int i = 0; i < 48; i++) x[i] = r[5'(E_TAB[i] - 1)] ^ k[i];
    for (int s = 0; s < 8; s++) begin
      row = 2 * int'(x[6*s]) + int'(x[6*s+5]);
      col = 8 * int'(x[6*s+1]) + 4 * int'(x[6*s+2]) + 2 * int'(x[6*s+3]) + int'(x[6*s+4]);
      v = SBOX_TAB[s][row*16 + col];
      for (int b = 0; b < 4; b++) s_out[4*s+b] = v[3-b];
    end
    for (int i = 0; i < 32; i++) y[i] = s_out[5'(P_TAB[i] - 1)];
    return y;
  endfunction

  // Textbook DES: all 16 subkeys from cumulative left shifts, decrypt uses them reversed.
  function automatic logic [0:63] ref_des(input logic [0:63] key, input logic [0:63] blk,
                                          input bit dec, input bit use_ip);
    logic [0:55] cd, rot;
    logic [0:47] ks [16];
    logic [0:63] x, y;
    logic [0:31] l, r, t;
    int tot;
    for (int i = 0; i < 56; i++) cd[i] = key[6'(PC1_TAB[i] - 1)];
    tot = 0;
    for (int n = 0; n < 16; n++) begin
      tot += SHIFT_TAB[n];
      for (int j = 0; j < 28; j++) begin
        rot[j]      = cd[(j + tot) % 28];
        rot[28 + j] = cd[28 + (j + tot) % 28];
      end
      for (int i = 0; i < 48; i++) ks[n][i] = rot[6'(PC2_TAB[i] - 1)];
    end
    x = blk;
    if (use_ip) for (int i = 0; i < 64; i++) x[i] = blk[6'(IP_TAB[i] - 1)];
    l = x[0:31];
    r = x[32:63];
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ ref_f(r, ks[dec ? 15 - n : n]);
      l = t;
    end
    y = {r, l};
    x = y;
    if (use_ip) for (int i = 0; i < 64; i++) x[i] = y[6'(FP_TAB[i] - 1)];
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents a block, waits (bounded) for in_ready, and returns just after the accepting edge.
  task automatic applyStimulus(input int u, input logic [63:0] key, input logic [63:0] blk, input logic dec);
    int n;
    n = 0;
    in_key[u]     = key;
    in_block[u]   = blk;
    in_decrypt[u] = dec;
    in_valid[u]   = 1'b1;
    #1;
    while (!in_ready[u] && n < 64) begin
      tick();
      #1;
      n++;
    end
    if (n >= 64) checkOutput("accept_timeout", 64'(n), 64'(0));
    tick();
    in_valid[u]   = 1'b0;
    in_block[u]   = {$urandom, $urandom};
    in_key[u]     = {$urandom, $urandom};
    in_decrypt[u] = 1'($urandom % 2);
  endtask

  task automatic waitOut(input int u, input bit rnd, output int n);
    n = 0;
    while (!out_valid[u] && n < 40) begin
      if (rnd) out_ready[u] = 1'($urandom % 2);
      tick();
      n++;
    end
    if (rnd) out_ready[u] = 1'b0;
  endtask

  task automatic consume(input int u);
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, n2, pulses, stalls;
    logic [63:0] key, blk, exp;
    logic dec;

    for (int u = 0; u < NI; u++) begin
      in_valid[u] = 1'b0; in_block[u] = '0; in_key[u] = '0;
      in_decrypt[u] = 1'b0; out_ready[u] = 1'b0;
    end
    @(negedge clk);
    #1;
    for (int u = 0; u < NI; u++) begin
      checkOutput("reset_flags", 64'({out_valid[u], in_ready[u], busy[u]}), 64'(0));
      checkOutput("reset_block", out_block[u], 64'(0));
    end
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_reset_ready", 64'(in_ready[0]), 64'(1));

    $display("[TB] encrypt known answer, UNROLL=1");
    applyStimulus(0, K1, PT1, 1'b0);
    waitOut(0, 1'b0, n);
    checkOutput("t1_latency", 64'(n), 64'(16));
    checkOutput("t1_block", out_block[0], CT1);
    consume(0);
    checkOutput("t1_idle", 64'({out_valid[0], in_ready[0]}), 64'(2'b01));

    $display("[TB] decrypt known answer, UNROLL=4");
    applyStimulus(2, K1, CT1, 1'b1);
    waitOut(2, 1'b0, n);
    checkOutput("t2_latency", 64'(n), 64'(4));
    checkOutput("t2_block", out_block[2], PT1);
    consume(2);

    $display("[TB] UNROLL=16 with output stall");
    applyStimulus(4, K3, PT3, 1'b0);
    waitOut(4, 1'b0, n);
    checkOutput("t3_latency", 64'(n), 64'(1));
    checkOutput("t3_block", out_block[4], CT3);
    in_valid[4] = 1'b1;
    in_block[4] = PT1;
    in_key[4]   = K1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_hold_flags", 64'({out_valid[4], in_ready[4], busy[4]}), 64'(3'b100));
      checkOutput("t3_hold_block", out_block[4], CT3);
    end
    in_valid[4] = 1'b0;
    consume(4);

    $display("[TB] back-to-back, UNROLL=2");
    in_key[1] = K1; in_block[1] = PT1; in_decrypt[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    tick();
    in_key[1] = K3; in_block[1] = PT3;
    waitOut(1, 1'b0, n);
    checkOutput("t4_first_latency", 64'(n), 64'(8));
    checkOutput("t4_first_block", out_block[1], CT1);
    checkOutput("t4_handoff_ready", 64'(in_ready[1]), 64'(1));
    tick();
    in_valid[1] = 1'b0;
    checkOutput("t4_reaccept", 64'({out_valid[1], busy[1]}), 64'(2'b01));
    waitOut(1, 1'b0, n2);
    checkOutput("t4_second_latency", 64'(n2), 64'(8));
    checkOutput("t4_second_block", out_block[1], CT3);
    tick();
    out_ready[1] = 1'b0;
    checkOutput("t4_drained", 64'(out_valid[1]), 64'(0));

    $display("[TB] reset mid-run, UNROLL=1");
    applyStimulus(0, K1, PT1, 1'b0);
    repeat (8) tick();
    checkOutput("t5_running", 64'(busy[0]), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_flags", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(0));
    checkOutput("t5_rst_block", out_block[0], 64'(0));
    in_valid[0] = 1'b1;
    in_block[0] = PT3;
    tick();
    checkOutput("t5_rst_noaccept", 64'({in_ready[0], busy[0]}), 64'(0));
    in_valid[0] = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("t5_after_release", 64'({out_valid[0], in_ready[0], busy[0]}), 64'(3'b010));
    pulses = 0;
    repeat (20) begin
      tick();
      pulses += int'(out_valid[0]);
    end
    checkOutput("t5_no_pulse", 64'(pulses), 64'(0));
    applyStimulus(0, K3, PT3, 1'b0);
    waitOut(0, 1'b0, n);
    checkOutput("t5_latency", 64'(n), 64'(16));
    checkOutput("t5_block", out_block[0], CT3);
    consume(0);

    $display("[TB] randomized blocks on every configuration");
    for (int u = 0; u < NI; u++) begin
      for (int it = 0; it < 6; it++) begin
        key = {$urandom, $urandom};
        blk = {$urandom, $urandom};
        dec = 1'($urandom % 2);
        exp = ref_des(key, blk, dec, use_ip_of(u));
        applyStimulus(u, key, blk, dec);
        waitOut(u, 1'b1, n);
        checkOutput("rnd_latency", 64'(n), 64'(16 / unroll_of(u)));
        stalls = int'($urandom % 4);
        repeat (stalls) tick();
        checkOutput("rnd_block", out_block[u], exp);
        consume(u);
        applyStimulus(u, key, exp, !dec);
        waitOut(u, 1'b1, n);
        checkOutput("rnd_roundtrip", out_block[u], blk);
        consume(u);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
